multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multicycle MIPS datapath: a Moore state machine with memory-ready gating that replaces the single-cycle opcode/funct decode. Each instruction is stepped through fetch, decode, execute, memory and writeback. The block drives every datapath mux select, write strobe and ALU operation. It also flags illegal encodings and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward
- Funct  in  6  instruction[5:0] from the instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory has completed the current access this cycle
- IorD, IRWrite, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA, Branch  out  1 each  datapath strobes and selects
- PCEn  out  1  PC load enable
- PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- ALUSrcB  out  2  ALU B source: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported encoding
- retired  out  32  count of retired instructions
- state  out  4  current state, for debug

## Operation
- State encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPEEX=7, RTYPEWB=8, BEQEX=9, ADDIEX=10, ADDIWB=11, JEX=12. Codes 13–15 go to FETCH on the next clock with all outputs 0.
- Supported encodings:
  - lw 100011
  - sw 101011
  - R-type 000000, with Funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - beq 000100
  - addi 001000
  - j 000010
- Default for every output not listed below is 0; ALUControl defaults to 010.
- Per-state outputs:
  - RESET: all outputs 0; goes to FETCH unconditionally.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00. IRWrite=PCEn=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by Opcode:
    - lw or sw → MEMADR
    - R-type with supported Funct → RTYPEEX
    - beq → BEQEX
    - addi → ADDIEX
    - j → JEX
    - anything else (including R-type with unsupported Funct) → FETCH with illegal_op=1; the instruction does not retire.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Goes to FETCH.
  - MEMWR: IorD=1, MemWrite=1. Holds until mem_ready=1, then goes to FETCH.
  - RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct. Goes to RTYPEWB.
  - RTYPEWB: RegDst=1, MemToReg=0, RegWrite=1. Goes to FETCH.
  - BEQEX: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01, PCEn=Zero. Goes to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Goes to ADDIWB.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Goes to FETCH.
  - JEX: PCSrc=10, PCEn=1. Goes to FETCH.
- instr_done=1 in the final state of each instruction:
  - MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX
  - MEMWR only in a cycle with mem_ready=1
- retired increments by 1 on every clock edge where instr_done=1; it wraps from 0xFFFFFFFF to 0.

## Timing
- Asynchronous reset: rst_n=0 forces state=RESET and retired=0 immediately. All outputs are 0 while rst_n=0.
- The first FETCH is one cycle after rst_n deasserts.
- Reset mid-instruction aborts it: no strobe is asserted after rst_n falls and the count does not change.
- The state register and retired are the only flops. Outputs are combinational from state, plus the mem_ready, Zero and Funct terms listed in Operation; there is no output register stage.
- Instruction latency with mem_ready held at 1 (FETCH through last state): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → all outputs 0 and state=0 during reset; state=1 on the first clock after release; retired=0.
- add: feed add (Opcode 000000, Funct 100000) with mem_ready=1 → states 1,2,7,8; ALUControl=010 in RTYPEEX; RegWrite=1 and RegDst=1 in RTYPEWB; retired=1 after 4 cycles.
- lw with wait states: mem_ready=0 for 2 cycles in FETCH and 1 cycle in MEMRD → IRWrite=PCEn=0 during the waits; 8 cycles total; MemToReg=1 and RegWrite=1 in MEMWB.
- beq: Zero=1 → PCEn=1 and PCSrc=01 in BEQEX. Zero=0 → PCEn=0. Both cases take 3 cycles and increment retired.
- Illegal encodings: Opcode 111111, or R-type with Funct 000111 → illegal_op=1 for one cycle in DECODE, next state FETCH, retired unchanged.
- sw interrupted by reset: drop rst_n while in MEMWR with mem_ready=0 → MemWrite falls to 0 immediately, state=0, retired=0. Separately, preload retired=0xFFFFFFFF and retire a j → retired=0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Purpose: controller <-> datapath bundle for the multicycle MIPS core.
// Latency: none (wires only).
// Backpressure: mem_ready from the unified memory stalls the controller.
// Ports: master = sequencing controller (drives strobes/selects, reads
//        opcode/funct/flags); slave = datapath side (the mirror image).
interface multicycle_control_fsm_if;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_ready;

    logic        IorD;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemToReg;
    logic        ALUSrcA;
    logic        Branch;
    logic        PCEn;
    logic [1:0]  PCSrc;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic        instr_done;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state;

    modport master (
        input  Opcode, Funct, Zero, mem_ready,
        output IorD, IRWrite, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA,
               Branch, PCEn, PCSrc, ALUSrcB, ALUControl, instr_done,
               illegal_op, retired, state
    );

    modport slave (
        output Opcode, Funct, Zero, mem_ready,
        input  IorD, IRWrite, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA,
               Branch, PCEn, PCSrc, ALUSrcB, ALUControl, instr_done,
               illegal_op, retired, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Purpose: Moore sequencer for the multicycle MIPS datapath (fetch/decode/exec/mem/wb).
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles, +1 per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: holds in FETCH, MEMRD and MEMWR until mem_ready=1; strobes gated by mem_ready there.
// Ports: clk, rst_n (async active-low); bus (master modport) carries Opcode/Funct/Zero/mem_ready
//        in and all datapath strobes, ALU op, instr_done, illegal_op, retired count and state out.
module multicycle_control_fsm (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] retired_q;

    logic        rtype_ok;
    logic [2:0]  rtype_alu;

    logic        iord_c;
    logic        irwrite_c;
    logic        memwrite_c;
    logic        regwrite_c;
    logic        regdst_c;
    logic        memtoreg_c;
    logic        alusrca_c;
    logic        branch_c;
    logic        pcen_c;
    logic [1:0]  pcsrc_c;
    logic [1:0]  alusrcb_c;
    logic [2:0]  aluctl_c;
    logic        done_c;
    logic        illegal_c;

    // Funct decode is shared by DECODE (legality) and RTYPEEX (ALU op).
    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = ALU_ADD;
        case (bus.Funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_SLT:  rtype_alu = ALU_SLT;
            default: rtype_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord_c     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        alusrca_c  = 1'b0;
        branch_c   = 1'b0;
        pcen_c     = 1'b0;
        pcsrc_c    = 2'b00;
        alusrcb_c  = 2'b00;
        aluctl_c   = ALU_ADD;
        done_c     = 1'b0;
        illegal_c  = 1'b0;

        case (state_q)
            S_RESET: begin
                // RESET drives everything low, ALU op included, so the
                // outputs are all-zero for the whole time rst_n is held.
                aluctl_c = 3'b000;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                alusrcb_c = 2'b01;
                irwrite_c = bus.mem_ready;
                pcen_c    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    OP_RTYPE: begin
                        if (rtype_ok) begin
                            state_d = S_RTYPEEX;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_c = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                // Store retires only on the cycle memory accepts it.
                done_c     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca_c = 1'b1;
                aluctl_c  = rtype_alu;
                state_d   = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca_c = 1'b1;
                aluctl_c  = ALU_SUB;
                branch_c  = 1'b1;
                pcsrc_c   = 2'b01;
                pcen_c    = bus.Zero;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc_c = 2'b10;
                pcen_c  = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unused codes 13-15: recover to FETCH with outputs quiet.
                aluctl_c = 3'b000;
                state_d  = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else if (done_c) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.IorD       = iord_c;
    assign bus.IRWrite    = irwrite_c;
    assign bus.MemWrite   = memwrite_c;
    assign bus.RegWrite   = regwrite_c;
    assign bus.RegDst     = regdst_c;
    assign bus.MemToReg   = memtoreg_c;
    assign bus.ALUSrcA    = alusrca_c;
    assign bus.Branch     = branch_c;
    assign bus.PCEn       = pcen_c;
    assign bus.PCSrc      = pcsrc_c;
    assign bus.ALUSrcB    = alusrcb_c;
    assign bus.ALUControl = aluctl_c;
    assign bus.instr_done = done_c;
    assign bus.illegal_op = illegal_c;
    assign bus.retired    = retired_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Purpose: directed self-checking bench for multicycle_control_fsm.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: mem_ready toggled by the stimulus to exercise wait states.
module tb_multicycle_control_fsm;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {IorD,IRWrite,MemWrite,RegWrite,RegDst,MemToReg,ALUSrcA,Branch,PCEn,PCSrc,ALUSrcB,ALUControl,instr_done,illegal_op}
    logic [17:0] outs;
    assign outs = {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.RegDst,
                   bus.MemToReg, bus.ALUSrcA, bus.Branch, bus.PCEn, bus.PCSrc,
                   bus.ALUSrcB, bus.ALUControl, bus.instr_done, bus.illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== 18'd0 || bus.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_outs outs=%b state=%0d required outs=0 state=0", outs, bus.state);
        end
        checks++;
        if (bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired got=%0d required=0", bus.retired);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL reset_first_fetch state=%0d required=1", bus.state);
        end
    endtask

    task automatic test_add;
        logic [31:0] r0;
        r0 = bus.retired;
        bus.Opcode = 6'b000000; bus.Funct = 6'b100000; bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd1 || bus.IRWrite !== 1'b1 || bus.PCEn !== 1'b1 ||
            bus.ALUSrcB !== 2'b01 || bus.ALUControl !== 3'b010 || bus.IorD !== 1'b0) begin
            errors++;
            $display("FAIL add_fetch state=%0d irw=%b pcen=%b srcb=%b alu=%b required 1/1/1/01/010",
                     bus.state, bus.IRWrite, bus.PCEn, bus.ALUSrcB, bus.ALUControl);
        end
        tick();
        checks++;
        if (bus.state !== 4'd2 || bus.ALUSrcB !== 2'b11 || bus.ALUControl !== 3'b010 ||
            bus.illegal_op !== 1'b0 || bus.IRWrite !== 1'b0) begin
            errors++;
            $display("FAIL add_decode state=%0d srcb=%b alu=%b ill=%b required 2/11/010/0",
                     bus.state, bus.ALUSrcB, bus.ALUControl, bus.illegal_op);
        end
        tick();
        checks++;
        if (bus.state !== 4'd7 || bus.ALUControl !== 3'b010 || bus.ALUSrcA !== 1'b1 ||
            bus.ALUSrcB !== 2'b00 || bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL add_exec state=%0d alu=%b srca=%b srcb=%b required 7/010/1/00",
                     bus.state, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB);
        end
        tick();
        checks++;
        if (bus.state !== 4'd8 || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b1 ||
            bus.MemToReg !== 1'b0 || bus.instr_done !== 1'b1) begin
            errors++;
            $display("FAIL add_wb state=%0d regw=%b regdst=%b m2r=%b done=%b required 8/1/1/0/1",
                     bus.state, bus.RegWrite, bus.RegDst, bus.MemToReg, bus.instr_done);
        end
        tick();
        checks++;
        if (bus.state !== 4'd1 || bus.retired !== r0 + 32'd1) begin
            errors++;
            $display("FAIL add_retire state=%0d retired=%0d required state=1 retired=%0d",
                     bus.state, bus.retired, r0 + 32'd1);
        end
    endtask

    task automatic test_rtype_alu;
        logic [5:0] fn [5];
        logic [2:0] op [5];
        fn[0] = 6'b100000; op[0] = 3'b010;
        fn[1] = 6'b100010; op[1] = 3'b110;
        fn[2] = 6'b100100; op[2] = 3'b000;
        fn[3] = 6'b100101; op[3] = 3'b001;
        fn[4] = 6'b101010; op[4] = 3'b111;
        for (int i = 0; i < 5; i++) begin
            bus.Opcode = 6'b000000; bus.Funct = fn[i]; bus.mem_ready = 1'b1;
            tick();
            tick();
            checks++;
            if (bus.state !== 4'd7 || bus.ALUControl !== op[i]) begin
                errors++;
                $display("FAIL rtype_alu funct=%b state=%0d alu=%b required state=7 alu=%b",
                         fn[i], bus.state, bus.ALUControl, op[i]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_lw_wait;
        logic [31:0] r0;
        int          cyc;
        r0 = bus.retired;
        cyc = 1;
        bus.Opcode = 6'b100011; bus.Funct = 6'b000000; bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.state !== 4'd1 || bus.IRWrite !== 1'b0 || bus.PCEn !== 1'b0) begin
                errors++;
                $display("FAIL lw_fetch_wait%0d state=%0d irw=%b pcen=%b required 1/0/0",
                         i, bus.state, bus.IRWrite, bus.PCEn);
            end
            tick(); cyc++;
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.IRWrite !== 1'b1 || bus.PCEn !== 1'b1) begin
            errors++;
            $display("FAIL lw_fetch_go irw=%b pcen=%b required 1/1", bus.IRWrite, bus.PCEn);
        end
        tick(); cyc++;
        tick(); cyc++;
        checks++;
        if (bus.state !== 4'd3 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10 ||
            bus.ALUControl !== 3'b010) begin
            errors++;
            $display("FAIL lw_memadr state=%0d srca=%b srcb=%b alu=%b required 3/1/10/010",
                     bus.state, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl);
        end
        tick(); cyc++;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd4 || bus.IorD !== 1'b1 || bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL lw_memrd_wait state=%0d iord=%b done=%b required 4/1/0",
                     bus.state, bus.IorD, bus.instr_done);
        end
        tick(); cyc++;
        bus.mem_ready = 1'b1;
        checks++;
        if (bus.state !== 4'd4) begin
            errors++;
            $display("FAIL lw_memrd_hold state=%0d required=4", bus.state);
        end
        tick(); cyc++;
        checks++;
        if (bus.state !== 4'd5 || bus.MemToReg !== 1'b1 || bus.RegWrite !== 1'b1 ||
            bus.RegDst !== 1'b0 || bus.instr_done !== 1'b1 || cyc !== 8) begin
            errors++;
            $display("FAIL lw_memwb state=%0d m2r=%b regw=%b regdst=%b done=%b cycle=%0d required 5/1/1/0/1 cycle 8",
                     bus.state, bus.MemToReg, bus.RegWrite, bus.RegDst, bus.instr_done, cyc);
        end
        tick();
        checks++;
        if (bus.state !== 4'd1 || bus.retired !== r0 + 32'd1) begin
            errors++;
            $display("FAIL lw_retire state=%0d retired=%0d required 1/%0d",
                     bus.state, bus.retired, r0 + 32'd1);
        end
    endtask

    task automatic test_beq;
        logic [31:0] r0;
        r0 = bus.retired;
        for (int z = 1; z >= 0; z--) begin
            bus.Opcode = 6'b000100; bus.Zero = z[0]; bus.mem_ready = 1'b1;
            tick();
            tick();
            checks++;
            if (bus.state !== 4'd9 || bus.PCEn !== z[0] || bus.PCSrc !== 2'b01 ||
                bus.Branch !== 1'b1 || bus.ALUControl !== 3'b110 || bus.instr_done !== 1'b1) begin
                errors++;
                $display("FAIL beq_zero%0d state=%0d pcen=%b pcsrc=%b br=%b alu=%b done=%b required 9/%0d/01/1/110/1",
                         z, bus.state, bus.PCEn, bus.PCSrc, bus.Branch, bus.ALUControl, bus.instr_done, z);
            end
            tick();
            checks++;
            if (bus.state !== 4'd1) begin
                errors++;
                $display("FAIL beq_return%0d state=%0d required=1", z, bus.state);
            end
        end
        checks++;
        if (bus.retired !== r0 + 32'd2) begin
            errors++;
            $display("FAIL beq_retired got=%0d required=%0d", bus.retired, r0 + 32'd2);
        end
        bus.Zero = 1'b0;
    endtask

    task automatic test_illegal;
        logic [31:0] r0;
        logic [5:0]  opc [2];
        logic [5:0]  fnc [2];
        opc[0] = 6'b111111; fnc[0] = 6'b100000;
        opc[1] = 6'b000000; fnc[1] = 6'b000111;
        r0 = bus.retired;
        for (int i = 0; i < 2; i++) begin
            bus.Opcode = opc[i]; bus.Funct = fnc[i]; bus.mem_ready = 1'b1;
            tick();
            checks++;
            if (bus.state !== 4'd2 || bus.illegal_op !== 1'b1 || bus.instr_done !== 1'b0) begin
                errors++;
                $display("FAIL illegal_decode%0d state=%0d ill=%b done=%b required 2/1/0",
                         i, bus.state, bus.illegal_op, bus.instr_done);
            end
            tick();
            checks++;
            if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0 || bus.retired !== r0) begin
                errors++;
                $display("FAIL illegal_after%0d state=%0d ill=%b retired=%0d required 1/0/%0d",
                         i, bus.state, bus.illegal_op, bus.retired, r0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r0;
        r0 = bus.retired;
        bus.Opcode = 6'b001000; bus.mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.state !== 4'd10 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10 ||
            bus.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL addi_exec state=%0d srca=%b srcb=%b regw=%b required 10/1/10/0",
                     bus.state, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite);
        end
        tick();
        checks++;
        if (bus.state !== 4'd11 || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0 ||
            bus.MemToReg !== 1'b0 || bus.instr_done !== 1'b1) begin
            errors++;
            $display("FAIL addi_wb state=%0d regw=%b regdst=%b m2r=%b done=%b required 11/1/0/0/1",
                     bus.state, bus.RegWrite, bus.RegDst, bus.MemToReg, bus.instr_done);
        end
        tick();
        bus.Opcode = 6'b000010;
        tick();
        tick();
        checks++;
        if (bus.state !== 4'd12 || bus.PCSrc !== 2'b10 || bus.PCEn !== 1'b1 ||
            bus.instr_done !== 1'b1) begin
            errors++;
            $display("FAIL j_exec state=%0d pcsrc=%b pcen=%b done=%b required 12/10/1/1",
                     bus.state, bus.PCSrc, bus.PCEn, bus.instr_done);
        end
        tick();
        bus.Opcode = 6'b101011;
        tick();
        tick();
        tick();
        checks++;
        if (bus.state !== 4'd6 || bus.MemWrite !== 1'b1 || bus.IorD !== 1'b1 ||
            bus.instr_done !== 1'b1) begin
            errors++;
            $display("FAIL sw_memwr state=%0d memw=%b iord=%b done=%b required 6/1/1/1",
                     bus.state, bus.MemWrite, bus.IorD, bus.instr_done);
        end
        tick();
        checks++;
        if (bus.state !== 4'd1 || bus.retired !== r0 + 32'd3) begin
            errors++;
            $display("FAIL b2b_retired state=%0d retired=%0d required 1/%0d",
                     bus.state, bus.retired, r0 + 32'd3);
        end
    endtask

    task automatic test_sw_reset;
        bus.Opcode = 6'b101011; bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd6 || bus.MemWrite !== 1'b1 || bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL sw_wait state=%0d memw=%b done=%b required 6/1/0",
                     bus.state, bus.MemWrite, bus.instr_done);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b0 || bus.state !== 4'd0 || bus.retired !== 32'd0 || outs !== 18'd0) begin
            errors++;
            $display("FAIL sw_abort memw=%b state=%0d retired=%0d outs=%b required 0/0/0/0",
                     bus.MemWrite, bus.state, bus.retired, outs);
        end
        bus.mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.state !== 4'd1 || bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL sw_recover state=%0d retired=%0d required 1/0", bus.state, bus.retired);
        end
    endtask

    task automatic test_wrap;
        dut.retired_q = 32'hFFFF_FFFF;
        bus.Opcode = 6'b000010; bus.mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.state !== 4'd12 || bus.retired !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_pre state=%0d retired=%h required 12/ffffffff", bus.state, bus.retired);
        end
        tick();
        checks++;
        if (bus.retired !== 32'd0 || bus.state !== 4'd1) begin
            errors++;
            $display("FAIL wrap_post retired=%h state=%0d required 00000000/1", bus.retired, bus.state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.Opcode = 6'd0;
        bus.Funct = 6'd0;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_add();
        test_rtype_alu();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_sw_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout simulation exceeded 50000 time units");
        $fatal(1);
    end

endmodule
